square_seq: RTL and testbench
=============================

# square_seq

Sequential integer squarer, the inverse of the team's bit-serial integer square-root block. It takes an unsigned WIDTH-bit operand and computes its 2·WIDTH-bit square by shift-and-add over exactly WIDTH cycles. It uses the same start/state_bo handshake as the root block, so the two can be chained in the FEC lab datapath, for example to check a root result by squaring it back.

## Interface
- WIDTH, 16, operand width in bits; result width is 2·WIDTH
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  start request; sampled in IDLE and DONE only
- a_bi  in  WIDTH  unsigned operand; captured on the accepting edge, ignored otherwise
- y_bo  out  2·WIDTH  result register a·a; reset 0
- state_bo  out  3  status: 0 idle, 1 work, 2 finalize, 3 done; reset 0

## Operation
- Internal registers:
  - acc (2·WIDTH): accumulator
  - mcand (2·WIDTH): shifted multiplicand
  - mplier (WIDTH): multiplier bits
  - cnt (ceil(log2 WIDTH)): iteration counter
  - state (2 bits)
- IDLE (0): if start_i=1, load acc←0, mcand←zero-extended a_bi, mplier←a_bi, cnt←0, and go to WORK. Otherwise hold.
- WORK (1), each cycle:
  - if mplier[0], acc←acc+mcand (2·WIDTH-bit add; cannot overflow for the final result)
  - mcand←mcand<<1, mplier←mplier>>1, cnt←cnt+1
  - on the cycle where cnt=WIDTH−1, go to FIN
  - start_i is ignored
- FIN (2): y_bo←acc, go to DONE. start_i is ignored.
- DONE (3): y_bo holds. If start_i=1, behave exactly as IDLE-accept: reload operands and go to WORK, with y_bo keeping the old result until the next FIN. Otherwise stay in DONE indefinitely.
- state_bo always equals the registered state encoding.
- No early termination: latency is fixed regardless of operand value, including a_bi=0.
- Reset at any cycle returns all registers and outputs to 0 (IDLE) on that edge and discards any operation in flight.
- An unreachable state encoding returns to IDLE.

## Timing
- Edge k (state IDLE or DONE, start_i=1): operand captured; state_bo=1 after edge k.
- Edges k+1 … k+WIDTH: the WIDTH iterations; state_bo=2 after edge k+WIDTH.
- Edge k+WIDTH+1: y_bo valid and state_bo=3. Total latency is WIDTH+1 edges after the accepting edge (17 for WIDTH=16).
- Back-to-back: start_i held high in DONE restarts on the first DONE edge. Minimum period is WIDTH+2 cycles.
- a_bi changes after the accepting edge do not affect the result.

## Structure
- Shared package:
  - state encodings ST_IDLE=0, ST_WORK=1, ST_FIN=2, ST_DONE=3, shared with the root block's state_bo decoding
  - default WIDTH constant
- Single module. No sub-module is warranted, because the datapath is one adder and two shifters.
- Optional testbench-only wrapper, sqrt_square_loop, chains root→square_seq for round-trip checks; it is not synthesised.

## Test plan
- Reset: assert rst_i for 2 cycles mid-WORK (a_bi=300), then release → y_bo=0, state_bo=0; no DONE without a new start.
- Basic values: a_bi=0 → y_bo=0; a_bi=1 → y_bo=1. state_bo=3 exactly 17 edges after accept in both cases.
- Extremes: a_bi=65535 → y_bo=0xFFFE0001; a_bi=32768 → y_bo=0x40000000.
- Typical value plus operand stability: a_bi=12345 → y_bo=152399025. Toggle a_bi and pulse start_i during WORK/FIN → result unchanged, no restart.
- Restart from DONE: after a_bi=7 (y_bo=49), hold start_i with a_bi=9 → y_bo stays 49 through WORK/FIN, then becomes 81 with state_bo=3.
- Round trip: feed x=152399025 to the root block, then its result into square_seq → y_bo=152399025. Random sweep of 1000 operands is checked against a·a.

Source files
------------

// File: rtl/square_seq_pkg.sv
// Shared definitions for the sequential squarer: state encodings (common with
// the square-root block's state_bo decoding) and the default operand width.
package square_seq_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WORK = 2'd1,
      ST_FIN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Iteration counter width; a one-bit operand still needs a one-bit counter.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/square_seq_if.sv
// Start/status handshake and operand/result bus of the squarer, with the
// requester (master) and squarer (slave) views.
interface square_seq_if #(
   parameter int WIDTH = square_seq_pkg::DEFAULT_WIDTH
);

   logic                 start_i;
   logic [WIDTH-1:0]     a_bi;
   logic [2*WIDTH-1:0]   y_bo;
   logic [2:0]           state_bo;

   modport master (
      output start_i,
      output a_bi,
      input  y_bo,
      input  state_bo
   );

   modport slave (
      input  start_i,
      input  a_bi,
      output y_bo,
      output state_bo
   );

endinterface

// File: rtl/square_seq.sv
// Shift-and-add integer squarer: WIDTH fixed iterations, then one finalize
// cycle that publishes the accumulator to y_bo.
module square_seq
   import square_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic        clk_i,
   input  logic        rst_i,
   square_seq_if.slave bus
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t               state_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0]   y_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [CW-1:0]        cnt_q;
   logic [2*WIDTH-1:0]   acc_d;

   assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         y_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               // y_q is left alone so a restart from DONE keeps the old result visible.
               if (bus.start_i) begin
                  acc_q    <= '0;
                  mcand_q  <= {{WIDTH{1'b0}}, bus.a_bi};
                  mplier_q <= bus.a_bi;
                  cnt_q    <= '0;
                  state_q  <= ST_WORK;
               end
            end
            ST_WORK: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  state_q <= ST_FIN;
               end
            end
            ST_FIN: begin
               y_q     <= acc_q;
               state_q <= ST_DONE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.y_bo     = y_q;
   assign bus.state_bo = {1'b0, state_q};

endmodule

// File: tb/tb_square_seq.sv
// Directed bench for square_seq: a timeline model (result = a*a, state from
// cycles since accept) is compared every cycle, plus literal spot checks.
module tb_square_seq;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   square_seq_if #(.WIDTH(W)) bus ();

   square_seq #(.WIDTH(W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: what the outputs must be, from the accept time and a*a.
   logic [2:0]  exp_state = '0;
   logic [31:0] exp_y     = '0;
   logic [31:0] m_res     = '0;
   int          m_age     = 0;
   bit          cmp_en    = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         exp_state = 3'd0;
         exp_y     = '0;
         m_age     = 0;
         cmp_en    = 1'b1;
      end else if ((exp_state == 3'd0 || exp_state == 3'd3) && bus.start_i) begin
         m_res     = 32'(bus.a_bi) * 32'(bus.a_bi);
         m_age     = 0;
         exp_state = 3'd1;
      end else if (exp_state == 3'd1 || exp_state == 3'd2) begin
         m_age++;
         if (m_age == W) begin
            exp_state = 3'd2;
         end else if (m_age == W + 1) begin
            exp_state = 3'd3;
            exp_y     = m_res;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         n_checks++;
         if (bus.state_bo !== exp_state || bus.y_bo !== exp_y) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t state_bo=%0d y_bo=%0d expected state=%0d y=%0d",
                     $time, bus.state_bo, bus.y_bo, exp_state, exp_y);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // One transaction: accept a, optionally disturb inputs or hold start, then
   // check latency and result against literal expectations.
   task automatic do_op(input logic [15:0] a, input logic [31:0] req_y,
                        input bit disturb, input bit hold, input logic [31:0] old_y);
      int edges;
      @(negedge clk);
      bus.a_bi    = a;
      bus.start_i = 1'b1;
      @(posedge clk);
      edges = 0;
      @(negedge clk);
      if (!hold) bus.start_i = 1'b0;
      while (bus.state_bo != 3'd3 && edges < 40) begin
         if (hold) chk("y_hold_during_restart", bus.y_bo, old_y);
         if (disturb) begin
            bus.a_bi    = 16'($urandom_range(0, 65535));
            bus.start_i = 1'($urandom_range(0, 1));
         end
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      bus.start_i = 1'b0;
      chk("latency", 32'(edges), 32'd17);
      chk("result", bus.y_bo, req_y);
      $display("op a=%0d y_bo=%0d latency=%0d", a, bus.y_bo, edges);
   endtask

   function automatic longint isqrt(input longint x);
      longint r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   initial begin
      logic [15:0] ra;
      longint root;
      bus.start_i = 1'b0;
      bus.a_bi    = '0;
      rst         = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 32'(bus.state_bo), 32'd0);
      chk("reset_y", bus.y_bo, 32'd0);
      rst = 1'b0;

      // Reset in the middle of WORK discards the operation.
      @(negedge clk);
      bus.a_bi    = 16'd300;
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_work_state", 32'(bus.state_bo), 32'd1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      chk("post_reset_state", 32'(bus.state_bo), 32'd0);
      chk("post_reset_y", bus.y_bo, 32'd0);
      $display("reset mid-work: state_bo=%0d y_bo=%0d", bus.state_bo, bus.y_bo);

      do_op(16'd0,     32'd0,          1'b0, 1'b0, '0);
      do_op(16'd1,     32'd1,          1'b0, 1'b0, '0);
      do_op(16'd65535, 32'hFFFE0001,   1'b0, 1'b0, '0);
      do_op(16'd32768, 32'h40000000,   1'b0, 1'b0, '0);
      do_op(16'd12345, 32'd152399025,  1'b1, 1'b0, '0);
      do_op(16'd7,     32'd49,         1'b0, 1'b0, '0);
      do_op(16'd9,     32'd81,         1'b0, 1'b1, 32'd49);

      // Round trip through an integer square root.
      root = isqrt(longint'(152399025));
      do_op(16'(root), 32'd152399025, 1'b0, 1'b0, '0);

      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom_range(0, 65535));
         do_op(ra, 32'(ra) * 32'(ra), 1'b0, 1'b0, '0);
      end

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
